btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
- Shared front-end controller for NBTN push buttons.
- Synchronizes each raw input and samples all buttons on one common divided sample strobe. Each button gets an HIST-deep history shift register.
- A press is detected when the history equals one 0 followed by HIST-1 ones. Detected presses are queued as per-button pending flags.
- A round-robin arbiter serializes pending presses into a single valid/ready event stream (button id) for downstream modules, e.g. register-file stepping or shift-register clocking.

Parameters:
- NBTN, 4, number of button inputs.
- IDW, 2, width of evt_id; must satisfy 2^IDW >= NBTN.
- DIV, 100000, clk cycles per sample strobe (DIV >= 2). Benches use DIV=4.
- HIST, 8, history depth in samples (HIST >= 2). A press is 1 low sample followed by HIST-1 high samples.

Ports:
- clk  in  1  system clock; all state on posedge clk.
- reset  in  1  synchronous, active-high reset.
- btn_in  in  NBTN  raw asynchronous button levels, active high.
- evt_ready  in  1  downstream accepts event when high at a clk edge with evt_valid high.
- clr_overrun  in  1  synchronous clear of overrun.
- evt_valid  out  1  event offered.
- evt_id  out  IDW  index of pressed button; valid while evt_valid is high.
- pend  out  NBTN  registered pending flags (debug/status).
- overrun  out  1  sticky: a press arrived while that button's pending flag was already set.

Behaviour:
- Reset (sync, active-high, takes priority over all other logic): the following all reset to 0.
  - sync flops, histories, divider counter, pend, overrun, evt_valid, evt_id.
  - state = IDLE; last_grant = NBTN-1, so button 0 has first priority.
  - A reset during OFFER drops the event; it is never re-offered.
- Sync: two flops per bit; s[i] is the second-stage output.
- Divider: cnt counts 0..DIV-1 and wraps to 0. strobe is high in the cycle cnt == DIV-1.
- History: on strobe, hist[i] <= {hist[i][HIST-2:0], s[i]}. Otherwise it holds.
- Detect: det[i] is high in the cycle after a strobe if hist[i] == {1'b0, (HIST-1){1'b1}}.
  - It fires exactly once per qualifying press.
  - A held button does not repeat (the pattern cannot recur without a low sample).
- Pending/overrun, per bit i:
  - det[i] & ~pend[i]: pend[i] <= 1.
  - det[i] & pend[i]: pend stays 1; overrun <= 1 (presses merge, no second event).
  - Grant clear and det[i] on the same bit in the same cycle: set wins, pend[i] stays 1, no overrun.
  - clr_overrun & overrun-set in the same cycle: set wins.
- Arbiter FSM:
  - IDLE:
    - If pend != 0, select the first set bit searching last_grant+1, last_grant+2, ... modulo NBTN.
    - Register evt_id <= sel, clear pend[sel], evt_valid <= 1, go to OFFER.
    - If pend == 0, stay in IDLE with evt_valid = 0.
  - OFFER:
    - evt_valid = 1; evt_id is held stable.
    - On evt_ready = 1 at an edge: evt_valid <= 0, last_grant <= evt_id, go to IDLE.
    - On evt_ready = 0, stay in OFFER (no timeout).
  - Throughput: at most one event per 2 cycles.
  - A pending bit is never cleared except by grant or reset.
  - evt_ready is ignored while evt_valid = 0.
- Latency:
  - From btn_in rise to det: 2 sync cycles plus HIST-1 strobes plus 1 cycle.
  - evt_valid rises 1 cycle after pend sets if the FSM is in IDLE.

Test Plan:
- Reset: assert reset 3 cycles with btn_in=4'hF. Required: evt_valid=0, evt_id=0, pend=0, overrun=0. After release, the first event is id 0 only after HIST-1 strobes of stable-high samples with a preceding low sample; with btn_in held high from reset, histories go 0→0x7F. Result: exactly one event per button, in order 0,1,2,3, with evt_ready=1.
- Clean press, DIV=4, HIST=8: btn_in[2] rises and holds, evt_ready=1. Required: single event id=2, evt_valid high exactly 1 cycle, pend=0 afterwards, no further events while held.
- Bounce: btn_in[1] toggles every 3 cycles for 40 cycles, then holds high. Required: exactly one event id=1, overrun=0.
- Simultaneous: btn_in[0] and btn_in[3] rise in the same cycle, evt_ready=1. Required: id 0, then id 3, two cycles apart. Then btn1 and btn3 pressed together: id 1 first (last_grant=3 wraps to 0, and 1 is the first set bit).
- Backpressure: evt_ready=0, press btn1 (event offered, id=1 held). Release and press btn1 again: pend[1]=1, overrun=0. Press a third time: overrun=1. Pulse clr_overrun: overrun=0. Raise evt_ready: id 1 accepted, then a second id 1 event.
- Reset mid-offer: in OFFER with evt_ready=0, assert reset 1 cycle. Required: evt_valid=0 the next cycle and state IDLE. No event appears without a new press.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// Button front end: synchronize, sample on a divided strobe, detect presses,
// queue them as pending flags and serialize them round-robin onto one event stream.
module btn_event_ctrl #(
    parameter int NBTN = 4,
    parameter int IDW  = 2,
    parameter int DIV  = 100000,
    parameter int HIST = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_in,
    input  logic            evt_ready,
    input  logic            clr_overrun,
    output logic            evt_valid,
    output logic [IDW-1:0]  evt_id,
    output logic [NBTN-1:0] pend,
    output logic            overrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [HIST-1:0] PAT = {1'b0, {(HIST-1){1'b1}}};
    localparam logic IDLE  = 1'b0;
    localparam logic OFFER = 1'b1;

    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] s;
    logic [CW-1:0]   cnt;
    logic            strobe;
    logic            strobe_q;
    logic [HIST-1:0] hist [NBTN];
    logic [NBTN-1:0] det;
    logic            state;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  sel;
    logic            found;
    logic            grant;
    logic [NBTN-1:0] gmask;
    logic [NBTN-1:0] pend_n;
    logic            ovr_set;

    assign strobe = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            s        <= '0;
            cnt      <= '0;
            strobe_q <= 1'b0;
        end else begin
            sync1    <= btn_in;
            s        <= sync1;
            cnt      <= strobe ? '0 : cnt + 1'b1;
            strobe_q <= strobe;
        end
    end

    // det is only looked at in the cycle right after a history update
    for (genvar i = 0; i < NBTN; i++) begin : g_hist
        always_ff @(posedge clk) begin
            if (reset) begin
                hist[i] <= '0;
            end else if (strobe) begin
                hist[i] <= {hist[i][HIST-2:0], s[i]};
            end
        end
        assign det[i] = strobe_q && (hist[i] == PAT);
    end

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NBTN; k++) begin
            logic [IDW-1:0] ix;
            ix = IDW'((int'(last_grant) + k) % NBTN);
            if (!found && pend[ix]) begin
                found = 1'b1;
                sel   = ix;
            end
        end
    end

    assign grant   = (state == IDLE) && found;
    assign gmask   = grant ? (NBTN'(1) << sel) : '0;
    assign pend_n  = (pend & ~gmask) | det;
    assign ovr_set = |(det & pend & ~gmask);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            overrun    <= 1'b0;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            state      <= IDLE;
            last_grant <= IDW'(NBTN - 1);
        end else begin
            pend <= pend_n;
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (found) begin
                        evt_id    <= sel;
                        evt_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        evt_valid  <= 1'b0;
                        last_grant <= evt_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with DIV=4, HIST=8.
// Covers reset, clean press, bounce, simultaneous presses, backpressure, mid-offer reset.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic       evt_ready;
    logic       clr_overrun;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] pend;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    btn_event_ctrl #(.NBTN(4), .IDW(2), .DIV(4), .HIST(8)) dut (
        .clk(clk),
        .reset(reset),
        .btn_in(btn_in),
        .evt_ready(evt_ready),
        .clr_overrun(clr_overrun),
        .evt_valid(evt_valid),
        .evt_id(evt_id),
        .pend(pend),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for evt_valid, then check the offered id.
    task automatic wait_evt(input string tag, input logic [1:0] id,
                            input int budget);
        int n;
        n = 0;
        while (evt_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(evt_valid), 32'd1);
        chk({tag, "_id"}, 32'(evt_id), 32'(id));
    endtask

    task automatic no_evt(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        repeat (cycles) begin
            tick();
            if (evt_valid === 1'b1) cnt++;
        end
        chk(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        btn_in      = 4'hF;
        evt_ready   = 1'b0;
        clr_overrun = 1'b0;
        tick(3);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);

        reset     = 1'b0;
        evt_ready = 1'b1;
        wait_evt("rst_e0", 2'd0, 80);
        tick();
        chk("rst_gap0", 32'(evt_valid), 32'd0);
        tick();
        chk("rst_e1", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd1}));
        tick(2);
        chk("rst_e2", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd2}));
        tick(2);
        chk("rst_e3", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd3}));
        no_evt("rst_held_quiet", 60);
        chk("rst_ovr_end", 32'(overrun), 32'd0);
        btn_in = 4'h0;
        tick(40);

        btn_in[2] = 1'b1;
        wait_evt("clean", 2'd2, 80);
        chk("clean_pend_off", 32'(pend), 32'd0);
        tick();
        chk("clean_1cyc", 32'(evt_valid), 32'd0);
        chk("clean_pend", 32'(pend), 32'd0);
        no_evt("clean_hold", 100);
        btn_in[2] = 1'b0;
        tick(40);

        for (int k = 0; k < 14; k++) begin
            btn_in[1] = ~btn_in[1];
            tick(3);
        end
        chk("bounce_quiet", 32'(evt_valid), 32'd0);
        btn_in[1] = 1'b1;
        wait_evt("bounce", 2'd1, 80);
        no_evt("bounce_once", 80);
        chk("bounce_ovr", 32'(overrun), 32'd0);
        btn_in = 4'h0;
        tick(40);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(10);
        btn_in = 4'b1001;
        wait_evt("sim_a", 2'd0, 80);
        tick();
        chk("sim_gap", 32'(evt_valid), 32'd0);
        tick();
        chk("sim_b", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd3}));
        no_evt("sim_quiet", 40);
        btn_in = 4'h0;
        tick(40);
        btn_in = 4'b1010;
        wait_evt("sim2_a", 2'd1, 80);
        tick(2);
        chk("sim2_b", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd3}));
        chk("sim_ovr", 32'(overrun), 32'd0);
        btn_in = 4'h0;
        tick(40);

        evt_ready = 1'b0;
        btn_in[1] = 1'b1;
        wait_evt("bp_first", 2'd1, 80);
        chk("bp_pend0", 32'(pend), 32'd0);
        tick(5);
        chk("bp_hold", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd1}));
        btn_in[1] = 1'b0;
        tick(20);
        btn_in[1] = 1'b1;
        tick(60);
        chk("bp_pend1", 32'(pend), 32'b0010);
        chk("bp_no_ovr", 32'(overrun), 32'd0);
        btn_in[1] = 1'b0;
        tick(20);
        btn_in[1] = 1'b1;
        tick(60);
        chk("bp_ovr", 32'(overrun), 32'd1);
        chk("bp_pend_merge", 32'(pend), 32'b0010);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("bp_clr", 32'(overrun), 32'd0);
        chk("bp_still", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd1}));
        evt_ready = 1'b1;
        tick();
        chk("bp_acc", 32'(evt_valid), 32'd0);
        tick();
        chk("bp_second", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd1}));
        tick();
        chk("bp_done", 32'({evt_valid, pend}), 32'd0);
        no_evt("bp_quiet", 30);

        btn_in    = 4'h0;
        evt_ready = 1'b0;
        tick(20);
        btn_in[0] = 1'b1;
        wait_evt("mid_offer", 2'd0, 80);
        btn_in[0] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid", 32'(evt_valid), 32'd0);
        chk("mid_pend", 32'(pend), 32'd0);
        evt_ready = 1'b1;
        no_evt("mid_no_replay", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
